// File: rtl/lsu_if.sv
// Request/response and memory-bus signals of the load/store unit.
// The slave view is the lsu itself; the master view is the core plus the bus.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_wmask;
  logic [DATA_W-1:0]     bus_rdata;
  logic                  bus_wen;
  logic                  bus_ren;
  logic                  bus_done;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
           bus_rdata, bus_done,
    output req_ready, resp_valid, resp_rdata, resp_err,
           bus_addr, bus_wdata, bus_wmask, bus_wen, bus_ren
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
           bus_rdata, bus_done,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           bus_addr, bus_wdata, bus_wmask, bus_wen, bus_ren
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request at a time, bus-word aligned beats, boundary-crossing
// accesses split into two beats, extended load result or error response.
module lsu #(
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int TIMEOUT          = 0
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave io
);
  localparam int B  = DATA_W / 8;
  localparam int OW = $clog2(B);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

  typedef struct packed {
    logic          we;
    logic [1:0]    size;
    logic          sgn;
    logic [OW-1:0] off;
    logic          split;
  } req_t;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] wdata_hi_q, wdata_hi_d;
  logic [B-1:0]      wmask_hi_q, wmask_hi_d;
  logic [DATA_W-1:0] buf_lo_q, buf_lo_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [B-1:0]      bus_wmask_q, bus_wmask_d;
  logic              bus_wen_q, bus_wen_d;
  logic              bus_ren_q, bus_ren_d;

  logic [OW-1:0]       in_off;
  logic [3:0]          in_n;
  logic                in_split;
  logic                in_illegal;
  logic [2*DATA_W-1:0] wide;
  logic [2*B-1:0]      mask2;
  logic [2*DATA_W-1:0] rbuf;
  logic [DATA_W-1:0]   load_res;

  // Keep the low n bytes, then fill the rest with the sign bit or zero.
  function automatic logic [DATA_W-1:0] extend(input logic [2*DATA_W-1:0] b,
                                               input logic [1:0] sz, input logic sgn);
    logic [DATA_W-1:0] r;
    int nb;
    r  = b[DATA_W-1:0];
    nb = 8 << sz;
    if (nb < DATA_W)
      for (int i = 0; i < DATA_W; i++)
        if (i >= nb) r[i] = sgn & b[nb-1];
    return r;
  endfunction

  assign in_off     = io.req_addr[OW-1:0];
  assign in_n       = 4'd1 << io.req_size;
  assign in_split   = (5'(in_off) + 5'(in_n)) > 5'(B);
  assign in_illegal = (io.req_size == 2'd3 && DATA_W == 32) || (in_split && !ALLOW_MISALIGNED);
  assign wide       = {{DATA_W{1'b0}}, io.req_wdata} << {in_off, 3'b000};
  assign mask2      = (2*B)'((16'd1 << in_n) - 16'd1) << in_off;

  // The second beat's read data lands in the upper half; a single beat leaves it zero.
  assign rbuf     = (state_q == BEAT1) ? {io.bus_rdata, buf_lo_q} : {{DATA_W{1'b0}}, io.bus_rdata};
  assign load_res = extend(rbuf >> {req_q.off, 3'b000}, req_q.size, req_q.sgn);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    wdata_hi_d   = wdata_hi_q;
    wmask_hi_d   = wmask_hi_q;
    buf_lo_d     = buf_lo_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wmask_d  = bus_wmask_q;
    bus_wen_d    = bus_wen_q;
    bus_ren_d    = bus_ren_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (io.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          req_d = '{we: io.req_we, size: io.req_size, sgn: io.req_signed,
                    off: in_off, split: in_split};
          if (in_illegal) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = BEAT0;
            cnt_d       = '0;
            bus_addr_d  = {io.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
            bus_wen_d   = io.req_we;
            bus_ren_d   = !io.req_we;
            bus_wdata_d = io.req_we ? wide[DATA_W-1:0] : '0;
            bus_wmask_d = io.req_we ? mask2[B-1:0] : '0;
            wdata_hi_d  = io.req_we ? wide[2*DATA_W-1:DATA_W] : '0;
            wmask_hi_d  = io.req_we ? mask2[2*B-1:B] : '0;
          end
        end
      end
      BEAT0, BEAT1: begin
        if (io.bus_done) begin
          if (state_q == BEAT0 && req_q.split) begin
            state_d     = BEAT1;
            cnt_d       = '0;
            buf_lo_d    = io.bus_rdata;
            bus_addr_d  = bus_addr_q + ADDR_W'(B);
            bus_wdata_d = wdata_hi_q;
            bus_wmask_d = wmask_hi_q;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = req_q.we ? '0 : load_res;
            bus_wen_d    = 1'b0;
            bus_ren_d    = 1'b0;
          end
        end else if (TIMEOUT > 0 && cnt_q == TO_LAST) begin
          // Abandon the beat; an already-completed first write beat stays written.
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
          bus_wen_d    = 1'b0;
          bus_ren_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      wdata_hi_q   <= '0;
      wmask_hi_q   <= '0;
      buf_lo_q     <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wmask_q  <= '0;
      bus_wen_q    <= 1'b0;
      bus_ren_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      wdata_hi_q   <= wdata_hi_d;
      wmask_hi_q   <= wmask_hi_d;
      buf_lo_q     <= buf_lo_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wmask_q  <= bus_wmask_d;
      bus_wen_q    <= bus_wen_d;
      bus_ren_q    <= bus_ren_d;
    end
  end

  assign io.req_ready  = req_ready_q;
  assign io.resp_valid = resp_valid_q;
  assign io.resp_err   = resp_err_q;
  assign io.resp_rdata = resp_rdata_q;
  assign io.bus_addr   = bus_addr_q;
  assign io.bus_wdata  = bus_wdata_q;
  assign io.bus_wmask  = bus_wmask_q;
  assign io.bus_wen    = bus_wen_q;
  assign io.bus_ren    = bus_ren_q;
endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench: a byte-addressed memory stands in for the bus, requests push
// expected responses and beats, and monitors pop and compare them.
module tb_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(32), .DATA_W(32)) ia ();
  lsu_if #(.ADDR_W(32), .DATA_W(32)) ib ();

  lsu #(.ADDR_W(32), .DATA_W(32), .ALLOW_MISALIGNED(1'b1), .TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst), .io(ia));
  lsu #(.ADDR_W(32), .DATA_W(32), .ALLOW_MISALIGNED(1'b0), .TIMEOUT(0)) u_b (
    .clk(clk), .rst(rst), .io(ib));

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] data; logic [3:0] mask; } beat_t;

  resp_t      exp_q[$];
  beat_t      beat_q[$];
  logic [7:0] mem [0:1023];
  int  n_chk = 0, n_fail = 0, cyc = 0;
  int  wait_cnt = 0, hi_cnt = 0, n_resp = 0, last_resp_cyc = 0;
  bit  stall = 0, fast = 1, b_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bytes_of(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz,
                                             input logic sg);
    logic [31:0] v, a;
    int nb;
    nb = 1 << sz;
    v  = '0;
    for (int i = 0; i < nb; i++) begin
      a = addr + i;
      v[8*i +: 8] = mem[a[9:0]];
    end
    if (sg && nb < 4 && v[8*nb-1])
      for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Bus responder for unit A: optional random wait states, or never done when stalled.
  always @(negedge clk) begin : resp_a
    beat_t e;
    logic [31:0] a;
    if (ia.bus_wen || ia.bus_ren) begin
      check("strobe_excl", 32'(ia.bus_wen & ia.bus_ren), 32'd0);
      hi_cnt++;
      if (!stall && wait_cnt == 0) begin
        if (beat_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL beat_unexpected: got addr %h expected no beat", ia.bus_addr);
        end else begin
          e = beat_q.pop_front();
          check("beat_addr", ia.bus_addr, e.addr);
          check("beat_dir", {30'd0, ia.bus_wen, ia.bus_ren}, {30'd0, e.we, !e.we});
          if (e.we) begin
            check("beat_mask", 32'(ia.bus_wmask), 32'(e.mask));
            check("beat_data", ia.bus_wdata & bytes_of(e.mask), e.data);
          end
        end
        for (int l = 0; l < 4; l++) begin
          a = ia.bus_addr + l;
          if (ia.bus_wen && ia.bus_wmask[l]) mem[a[9:0]] = ia.bus_wdata[8*l +: 8];
          ia.bus_rdata[8*l +: 8] = mem[a[9:0]];
        end
        ia.bus_done = 1'b1;
        wait_cnt = fast ? 0 : int'($urandom_range(0, 2));
      end else begin
        ia.bus_done  = 1'b0;
        ia.bus_rdata = $urandom;
        if (!stall) wait_cnt--;
      end
    end else begin
      ia.bus_done  = 1'b0;
      ia.bus_rdata = $urandom;
    end
  end

  always @(negedge clk) begin : mon_a
    resp_t e;
    if (ia.resp_valid) begin
      n_resp++;
      last_resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL resp_unexpected: got rdata %h err %0d expected none", ia.resp_rdata, ia.resp_err);
      end else begin
        e = exp_q.pop_front();
        check("resp_err", 32'(ia.resp_err), 32'(e.err));
        check("resp_rdata", ia.resp_rdata, e.rdata);
      end
    end
  end

  always @(negedge clk) begin
    ib.bus_done  = ib.bus_ren | ib.bus_wen;
    ib.bus_rdata = 32'hCAFEF00D;
    if (ib.bus_ren | ib.bus_wen) b_seen = 1'b1;
  end

  // mode 0: normal, 1: stalled bus (timeout expected)
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input int mode);
    resp_t r;
    beat_t bt;
    int nb, off, c0, r0, t, p;
    nb = 1 << sz;
    off = int'(addr[1:0]);
    r.err   = (sz == 2'd3) || (mode == 1);
    r.rdata = (r.err || we) ? 32'd0 : model_load(addr, sz, sg);
    exp_q.push_back(r);
    if (!r.err)
      for (int b = 0; b < ((off + nb > 4) ? 2 : 1); b++) begin
        bt.addr = {addr[31:2], 2'b00} + 32'(4 * b);
        bt.we = we; bt.data = '0; bt.mask = '0;
        for (int i = 0; i < nb; i++) begin
          p = off + i;
          if (p / 4 == b) begin
            bt.mask[p % 4] = 1'b1;
            bt.data[8*(p % 4) +: 8] = wd[8*i +: 8];
          end
        end
        beat_q.push_back(bt);
      end
    t = 0;
    while (!ia.req_ready && t < 50) begin @(negedge clk); t++; end
    if (!ia.req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL ready_wait: got req_ready 0 expected 1");
    end
    ia.req_we = we; ia.req_size = sz; ia.req_signed = sg;
    ia.req_addr = addr; ia.req_wdata = wd; ia.req_valid = 1'b1;
    c0 = cyc; r0 = n_resp;
    @(negedge clk);
    ia.req_valid = 1'b0; ia.req_addr = $urandom; ia.req_wdata = $urandom;
    #1;
    t = 0;
    while (n_resp == r0 && t < 100) begin @(negedge clk); #1; t++; end
    if (n_resp == r0) begin
      n_chk++; n_fail++;
      $display("FAIL resp_wait: got no response expected one for addr %h", addr);
    end else if (exp_lat > 0) begin
      check("latency", 32'(last_resp_cyc - c0), 32'(exp_lat));
    end
    if (mode == 0) check("beats_left", 32'(beat_q.size()), 32'd0);
  endtask

  task automatic do_b(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                      input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                      input logic exp_seen);
    int c0, t;
    b_seen = 1'b0;
    t = 0;
    while (!ib.req_ready && t < 50) begin @(negedge clk); t++; end
    ib.req_we = we; ib.req_size = sz; ib.req_signed = sg;
    ib.req_addr = addr; ib.req_wdata = $urandom; ib.req_valid = 1'b1;
    c0 = cyc;
    @(negedge clk);
    ib.req_valid = 1'b0;
    t = 0;
    while (!ib.resp_valid && t < 50) begin @(negedge clk); t++; end
    if (!ib.resp_valid) begin
      n_chk++; n_fail++;
      $display("FAIL b_resp_wait: got no response expected one for addr %h", addr);
    end else begin
      check("b_err", 32'(ib.resp_err), 32'(exp_err));
      check("b_rdata", ib.resp_rdata, exp_rd);
      check("b_latency", 32'(cyc - c0), 32'(exp_lat));
      check("b_strobes", 32'(b_seen), 32'(exp_seen));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    int r0;
    ia.req_valid = 0; ia.req_we = 0; ia.req_size = 0; ia.req_signed = 0;
    ia.req_addr = 0; ia.req_wdata = 0; ia.bus_done = 0; ia.bus_rdata = 0;
    ib.req_valid = 0; ib.req_we = 0; ib.req_size = 0; ib.req_signed = 0;
    ib.req_addr = 0; ib.req_wdata = 0; ib.bus_done = 0; ib.bus_rdata = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    #2 rst = 1'b0;
    #1;
    check("rst_ready", 32'(ia.req_ready), 32'd0);
    check("rst_resp_valid", 32'(ia.resp_valid), 32'd0);
    check("rst_resp", {ia.resp_rdata[30:0], ia.resp_err}, 32'd0);
    check("rst_strobes", {30'd0, ia.bus_wen, ia.bus_ren}, 32'd0);
    check("rst_bus", ia.bus_addr | ia.bus_wdata | 32'(ia.bus_wmask), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_ready_held", 32'(ia.req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(ia.req_ready), 32'd1);

    // Directed cases, zero wait states
    fast = 1; wait_cnt = 0;
    {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]} = 32'hDEADBEEF;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 2, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h203, 32'h000000A5, 2, 0);
    mem[10'h103] = 8'h80; mem[10'h104] = 8'hFF;
    do_req(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 3, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'h11223344, 3, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 3, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1, 0);
    do_req(1'b0, 2'd2, 1'b1, 32'hFFFFFFFE, 32'h0, 3, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h104, 32'h0, 2, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h104, 32'h0, 2, 0);

    // Timeout: strobes stay up for exactly four beat cycles
    stall = 1; hi_cnt = 0;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 1);
    check("timeout_beat_cycles", 32'(hi_cnt), 32'd4);
    stall = 0; wait_cnt = 0;

    // Misalignment rejected by unit B, aligned traffic still served
    do_b(1'b0, 2'd2, 1'b0, 32'h100, 1'b0, 32'hCAFEF00D, 2, 1'b1);
    do_b(1'b0, 2'd1, 1'b1, 32'h102, 1'b0, 32'hFFFFCAFE, 2, 1'b1);
    do_b(1'b0, 2'd2, 1'b0, 32'h101, 1'b1, 32'h0, 1, 1'b0);
    do_b(1'b1, 2'd1, 1'b0, 32'h103, 1'b1, 32'h0, 1, 1'b0);

    // Randomized traffic with wait states
    fast = 0;
    for (int k = 0; k < 150; k++) begin
      logic [31:0] ad;
      logic [1:0]  sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                        : 32'($urandom_range(0, 1023));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, 0, 0);
    end
    fast = 1; wait_cnt = 0;

    // Reset in the middle of a beat: strobes drop, no response follows
    stall = 1;
    @(negedge clk);
    ia.req_we = 0; ia.req_size = 2'd2; ia.req_signed = 0; ia.req_addr = 32'h100; ia.req_valid = 1'b1;
    @(negedge clk);
    ia.req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_ren", 32'(ia.bus_ren), 32'd1);
    r0 = n_resp;
    rst = 1'b0;
    #1;
    check("mid_rst_strobes", {30'd0, ia.bus_wen, ia.bus_ren}, 32'd0);
    check("mid_rst_ready", 32'(ia.req_ready), 32'd0);
    check("mid_rst_resp_valid", 32'(ia.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_mid_rst", 32'(ia.req_ready), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    check("no_resp_after_rst", 32'(n_resp), 32'(r0));
    stall = 0;

    // Unit still healthy after the reset
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 2, 0);
    check("resp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Parametrised load/store unit sitting between the core's execute stage and the shared memory bus. It replaces the core's inline load/store datapath. It accepts one load or store request at a time and aligns write data and byte masks onto a DATA_W-wide bus. Accesses that cross a bus-word boundary are split into two bus transactions, and the unit returns a sign- or zero-extended load result or an error.

## Interface
- ADDR_W, 32: address width in bits.
- DATA_W, 32: bus data width in bits; legal values are 32 or 64.
- ALLOW_MISALIGNED, 1: 1 splits boundary-crossing accesses; 0 rejects them with an error.
- TIMEOUT, 0: maximum cycles to wait for bus_done per beat; 0 disables the timeout.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W=64).
- req_signed  in  1  sign-extend the load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle pulse when the request completes.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; set on illegal size, rejected misalignment or timeout.
- bus_addr  out  ADDR_W  bus-word-aligned address.
- bus_wdata  out  DATA_W  shifted store data.
- bus_wmask  out  DATA_W/8  byte enables.
- bus_rdata  in  DATA_W  read data, valid when bus_done=1.
- bus_wen, bus_ren  out  1  write/read strobes; at most one is high at a time.
- bus_done  in  1  current bus beat complete.

## Operation
- Derived values:
  - B = DATA_W/8.
  - off = req_addr mod B.
  - n = 1<<req_size.
  - split = (off+n > B).
- States:
  - IDLE: req_ready=1.
  - BEAT0 and BEAT1: bus strobes held.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- IDLE with req_valid=1 latches all req_* fields. The next state is:
  - RESP with err=1 if req_size=3 and DATA_W=32, or if split=1 and ALLOW_MISALIGNED=0. No bus activity occurs.
  - BEAT0 otherwise.
- Stores:
  - The 2B-byte vector wide = req_wdata << 8*off.
  - mask2 = ((1<<n)-1) << off.
  - BEAT0 drives the low halves of wide and mask2; BEAT1 drives the high halves.
- Loads:
  - The bus_rdata from BEAT0 goes to buffer[B-1:0]. The bus_rdata from BEAT1 goes to buffer[2B-1:B], which is zero if no second beat occurs.
  - result = (buffer >> 8*off), truncated to n bytes and extended per req_signed. A dword result is not extended.
- bus_addr:
  - BEAT0: req_addr with low log2(B) bits cleared.
  - BEAT1: that value plus B, wrapping modulo 2^ADDR_W.
- BEAT0 with bus_done=1 goes to BEAT1 if split, else RESP. BEAT1 with bus_done=1 goes to RESP.
- Timeout (TIMEOUT>0):
  - A per-beat counter clears on entry to each beat.
  - When the counter reaches TIMEOUT with bus_done=0, strobes drop and the unit goes to RESP with err=1.
  - A beat-0 write that has already completed is not undone.
- bus_done outside BEAT0/BEAT1 is ignored.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state IDLE.
  - req_ready=0 while rst is asserted, then 1 from the first edge after release.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - bus_wen=0, bus_ren=0, bus_addr=0, bus_wdata=0, bus_wmask=0.
- Reset asserted mid-beat drops the strobes immediately and produces no resp_valid.
- Request accepted at edge k:
  - Strobes are high from k+1 until the edge on which bus_done is sampled.
  - resp_valid is high in the cycle after the final bus_done.
- Minimum latency from request to resp_valid: 2 cycles for an aligned access, 3 for a split access, 1 for an error access.
- req_ready=0 from the accept edge until resp_valid has been high for one cycle. A new request can be accepted in the cycle after resp_valid.
- Between beats the strobes stay high and change bus_addr, bus_wdata and bus_wmask on the same edge.
- Outputs are registered; there is no combinational path from bus_rdata or bus_done to outputs.

## Test plan
- DATA_W=32, LW addr 0x100, bus_rdata 0xDEADBEEF, bus_done on the first beat cycle -> bus_addr=0x100, bus_ren for 1 cycle; resp_valid 2 cycles after accept with rdata 0xDEADBEEF, err=0.
- SB addr 0x203, wdata 0x000000A5 -> bus_addr=0x200, bus_wmask=1000, bus_wdata[31:24]=0xA5, one beat.
- LH signed addr 0x103 -> beat 0x100 returns 0x80xxxxxx and beat 0x104 returns 0xxxxxxxFF:
  - two read beats.
  - rdata=0xFFFFFF80 (byte 0x80 from 0x103 low, byte 0xFF from 0x104 high, assembled 0xFF80, sign-extended).
- SW addr 0x102, wdata 0x11223344 -> beat0 at 0x100 with mask 1100 and data[31:16]=0x3344; beat1 at 0x104 with mask 0011 and data[15:0]=0x1122.
- ALLOW_MISALIGNED=0, LW addr 0x101 -> no strobes; resp_valid next cycle with err=1, rdata=0.
- TIMEOUT=4, bus_done held 0 -> strobes drop after 4 beat cycles, resp err=1. Separately, rst pulsed low mid-beat -> strobes drop immediately and no response is produced.
